encoder4_2_sequencer: RTL and testbench

Sequential 4-to-2 encoder: the inverse of the 2-to-4 decoder. It captures a 4-bit line vector (Y3..Y0) on a load strobe. It then emits the 2-bit code {A,B} of every asserted line, one per valid/ready transfer, in fixed priority order. It sits downstream of decoded request lines and serialises them back into binary codes for a single consumer.

---
 rtl/encoder4_2_sequencer.sv | 119 +++++++++++
 tb/tb_encoder4_2_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/encoder4_2_sequencer.sv
// encoder4_2_sequencer
//   Captures a one-hot-style request vector Y3..Y0 on a load strobe and
//   serialises it back into 2-bit binary codes {A,B}, one per valid/ready
//   transfer, in fixed priority order.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   enable   0 freezes all state and blocks load/transfer
//   load     capture strobe for Y3..Y0 (honoured only in IDLE with enable=1)
//   Y0..Y3   request lines
//   ready    consumer accepts the current code this cycle
//   A, B     code MSB / LSB of the currently selected line
//   valid    {A,B} holds a pending code
//   busy     serving a captured vector
//   none     one-cycle pulse: load captured an all-zero vector
//   done     one-cycle pulse: last pending code transferred
//
// Parameter
//   PRIORITY_HIGH  1: Y3 served first, 0: Y0 served first
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for load; outputs idle
// ST_SERVE | presenting codes of remaining bits in pend
module encoder4_2_sequencer #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic load,
  input  logic Y0,
  input  logic Y1,
  input  logic Y2,
  input  logic Y3,
  input  logic ready,
  output logic A,
  output logic B,
  output logic valid,
  output logic busy,
  output logic none,
  output logic done
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  logic [0:0] state;
  logic [3:0] pend;
  logic [3:0] pend_clr;
  logic [3:0] y_vec;
  logic [1:0] sel;
  logic       none_q;
  logic       done_q;
  logic       transfer;

  assign y_vec = {Y3, Y2, Y1, Y0};

  always_comb begin
    sel = 2'd0;
    if (PRIORITY_HIGH) begin
      if      (pend[3]) sel = 2'd3;
      else if (pend[2]) sel = 2'd2;
      else if (pend[1]) sel = 2'd1;
      else              sel = 2'd0;
    end else begin
      if      (pend[0]) sel = 2'd0;
      else if (pend[1]) sel = 2'd1;
      else if (pend[2]) sel = 2'd2;
      else              sel = 2'd3;
    end
  end

  assign busy     = (state == ST_SERVE);
  assign valid    = busy && enable;
  assign transfer = valid && ready;
  assign pend_clr = pend & ~(4'b0001 << sel);

  // Code is forced to 00 in IDLE so a stale selection never leaks out.
  assign A    = busy & sel[1];
  assign B    = busy & sel[0];
  assign none = none_q;
  assign done = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      pend   <= 4'b0000;
      none_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      none_q <= 1'b0;
      done_q <= 1'b0;
      if (enable) begin
        case (state)
          ST_IDLE: begin
            if (load) begin
              pend <= y_vec;
              if (y_vec != 4'b0000) state  <= ST_SERVE;
              else                  none_q <= 1'b1;
            end
          end
          ST_SERVE: begin
            if (transfer) begin
              pend <= pend_clr;
              if (pend_clr == 4'b0000) begin
                state  <= ST_IDLE;
                done_q <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_encoder4_2_sequencer.sv
// Directed bench for encoder4_2_sequencer. Two instances share stimulus:
// u_hi (Y3 first) and u_lo (Y0 first). Observed outputs are packed as
// {A,B,valid,busy,none,done} and compared against hand-computed vectors.
module tb_encoder4_2_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic [3:0] y = 4'b0000;
  logic ready = 1'b0;

  logic a_hi, b_hi, valid_hi, busy_hi, none_hi, done_hi;
  logic a_lo, b_lo, valid_lo, busy_lo, none_lo, done_lo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  encoder4_2_sequencer #(.PRIORITY_HIGH(1'b1)) u_hi (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]), .ready(ready),
    .A(a_hi), .B(b_hi), .valid(valid_hi), .busy(busy_hi),
    .none(none_hi), .done(done_hi)
  );

  encoder4_2_sequencer #(.PRIORITY_HIGH(1'b0)) u_lo (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]), .ready(ready),
    .A(a_lo), .B(b_lo), .valid(valid_lo), .busy(busy_lo),
    .none(none_lo), .done(done_lo)
  );

  logic [5:0] out_hi, out_lo;
  assign out_hi = {a_hi, b_hi, valid_hi, busy_hi, none_hi, done_hi};
  assign out_lo = {a_lo, b_lo, valid_lo, busy_lo, none_lo, done_lo};

  // Packed expectation: {A,B,valid,busy,none,done}
  localparam logic [5:0] IDLE_O = 6'b00_0_0_0_0;
  localparam logic [5:0] DONE_O = 6'b00_0_0_0_1;
  localparam logic [5:0] NONE_O = 6'b00_0_0_1_0;
  localparam logic [5:0] C00    = 6'b00_1_1_0_0;
  localparam logic [5:0] C01    = 6'b01_1_1_0_0;
  localparam logic [5:0] C10    = 6'b10_1_1_0_0;
  localparam logic [5:0] C11    = 6'b11_1_1_0_0;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got AB_v_b_n_d=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] vec);
    y = vec;
    load = 1'b1;
    step();
    load = 1'b0;
    y = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("reset_hi", out_hi, IDLE_O);
    chk("reset_lo", out_lo, IDLE_O);
    step();
    rst = 1'b0;
    enable = 1'b1;
    step();
    chk("post_reset_hi", out_hi, IDLE_O);

    // 1010 with ready held high
    ready = 1'b1;
    do_load(4'b1010);
    chk("t1_c0_hi", out_hi, C11);
    chk("t1_c0_lo", out_lo, C01);
    step();
    chk("t1_c1_hi", out_hi, C01);
    chk("t1_c1_lo", out_lo, C11);
    step();
    chk("t1_done_hi", out_hi, DONE_O);
    chk("t1_done_lo", out_lo, DONE_O);
    step();
    chk("t1_idle_hi", out_hi, IDLE_O);

    // 1011 back-to-back
    do_load(4'b1011);
    chk("t2_c0_hi", out_hi, C11);
    chk("t2_c0_lo", out_lo, C00);
    step();
    chk("t2_c1_hi", out_hi, C01);
    chk("t2_c1_lo", out_lo, C01);
    step();
    chk("t2_c2_hi", out_hi, C00);
    chk("t2_c2_lo", out_lo, C11);
    step();
    chk("t2_done_hi", out_hi, DONE_O);
    chk("t2_done_lo", out_lo, DONE_O);

    // Reload in the done cycle: zero vector gives none
    do_load(4'b0000);
    chk("t3_none_hi", out_hi, NONE_O);
    chk("t3_none_lo", out_lo, NONE_O);
    step();
    chk("t3_after_hi", out_hi, IDLE_O);

    // 1111 with a 3-cycle stall
    ready = 1'b0;
    do_load(4'b1111);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_hi", out_hi, C11);
      chk("t4_stall_lo", out_lo, C00);
      if (i < 2) step();
    end
    ready = 1'b1;
    step();
    chk("t4_c1_hi", out_hi, C10);
    chk("t4_c1_lo", out_lo, C01);
    step();
    chk("t4_c2_hi", out_hi, C01);
    chk("t4_c2_lo", out_lo, C10);
    step();
    chk("t4_c3_hi", out_hi, C00);
    chk("t4_c3_lo", out_lo, C11);
    step();
    chk("t4_done_hi", out_hi, DONE_O);
    step();

    // 0110 with enable dropped mid-serve
    do_load(4'b0110);
    chk("t5_c0_hi", out_hi, C10);
    chk("t5_c0_lo", out_lo, C01);
    step();
    enable = 1'b0;
    #1;
    chk("t5_frz0_hi", out_hi, 6'b01_0_1_0_0);
    chk("t5_frz0_lo", out_lo, 6'b10_0_1_0_0);
    step();
    chk("t5_frz1_hi", out_hi, 6'b01_0_1_0_0);
    step();
    chk("t5_frz2_hi", out_hi, 6'b01_0_1_0_0);
    enable = 1'b1;
    #1;
    chk("t5_resume_hi", out_hi, C01);
    chk("t5_resume_lo", out_lo, C10);
    step();
    chk("t5_done_hi", out_hi, DONE_O);
    chk("t5_done_lo", out_lo, DONE_O);
    step();

    // load while busy is ignored
    do_load(4'b0110);
    chk("t6_c0_hi", out_hi, C10);
    ready = 1'b0;
    y = 4'b1000;
    load = 1'b1;
    step();
    load = 1'b0;
    y = 4'b0000;
    chk("t6_ign_hi", out_hi, C10);
    chk("t6_ign_lo", out_lo, C01);
    ready = 1'b1;
    step();
    chk("t6_c1_hi", out_hi, C01);
    chk("t6_c1_lo", out_lo, C10);
    step();
    chk("t6_done_hi", out_hi, DONE_O);
    chk("t6_done_lo", out_lo, DONE_O);
    step();

    // asynchronous reset mid-serve
    do_load(4'b1111);
    chk("t7_c0_hi", out_hi, C11);
    step();
    chk("t7_c1_hi", out_hi, C10);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_hi", out_hi, IDLE_O);
    chk("t7_rst_lo", out_lo, IDLE_O);
    step();
    rst = 1'b0;
    step();
    chk("t7_post_hi", out_hi, IDLE_O);
    step();
    chk("t7_post2_lo", out_lo, IDLE_O);
    do_load(4'b0001);
    chk("t7_reload_hi", out_hi, C00);
    chk("t7_reload_lo", out_lo, C00);
    step();
    chk("t7_reload_done", out_hi, DONE_O);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
